// File: rtl/sdram_port_arbiter_if.sv
// Two-port host request/grant bundle plus the command/response wires to the SDRAM controller.
// The slave modport is the arbiter's view; the master modport is the hosts-plus-controller side.
interface sdram_port_arbiter_if #(
    parameter int unsigned HADDR_WIDTH = 24
);
    localparam int unsigned DW = 16;

    logic                   p0_req;
    logic                   p0_we;
    logic [HADDR_WIDTH-1:0] p0_addr;
    logic [DW-1:0]          p0_wdata;
    logic                   p0_gnt;
    logic                   p0_done;
    logic [DW-1:0]          p0_rdata;

    logic                   p1_req;
    logic                   p1_we;
    logic [HADDR_WIDTH-1:0] p1_addr;
    logic [DW-1:0]          p1_wdata;
    logic                   p1_gnt;
    logic                   p1_done;
    logic [DW-1:0]          p1_rdata;

    logic [HADDR_WIDTH-1:0] ctl_wr_addr;
    logic [HADDR_WIDTH-1:0] ctl_rd_addr;
    logic [DW-1:0]          ctl_wr_data;
    logic                   ctl_wr_enable;
    logic                   ctl_rd_enable;
    logic                   ctl_busy;
    logic                   ctl_rd_ready;
    logic [DW-1:0]          ctl_rd_data;

    logic                   arb_busy;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_done, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_done, p1_rdata,
        input  ctl_wr_addr, ctl_rd_addr, ctl_wr_data, ctl_wr_enable, ctl_rd_enable,
        output ctl_busy, ctl_rd_ready, ctl_rd_data,
        input  arb_busy
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_done, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_done, p1_rdata,
        output ctl_wr_addr, ctl_rd_addr, ctl_wr_data, ctl_wr_enable, ctl_rd_enable,
        input  ctl_busy, ctl_rd_ready, ctl_rd_data,
        output arb_busy
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between two host ports.
// One access in flight: latch winner, strobe until controller busy, wait for busy to fall.
module sdram_port_arbiter #(
    parameter int unsigned HADDR_WIDTH = 24
) (
    input logic                 clk,
    input logic                 rst_n,
    sdram_port_arbiter_if.slave bus
);
    localparam int unsigned DW = 16;
    localparam int unsigned SW = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   cmd_we_q;
    logic [HADDR_WIDTH-1:0] cmd_addr_q;
    logic [DW-1:0]          cmd_wdata_q;
    logic                   owner_q;
    logic                   last_q;
    logic [SW-1:0]          stall_q;
    logic [DW-1:0]          rdata0_q, rdata1_q;

    logic any_req, sel;
    logic gnt0, gnt1, done0, done1, rd_en, wr_en;

    // Grant/done are same-cycle pulses; strobes decode the registered state.
    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        done0   = 1'b0;
        done1   = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        any_req = rst_n & (bus.p0_req | bus.p1_req);
        sel     = (bus.p0_req & bus.p1_req) ? ~last_q : bus.p1_req;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                    gnt0    = ~sel;
                    gnt1    = sel;
                end
            end
            ISSUE: begin
                rd_en = ~cmd_we_q;
                wr_en = cmd_we_q;
                if (bus.ctl_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.ctl_busy) begin
                    state_d = IDLE;
                    done0   = ~owner_q;
                    done1   = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Command register, round-robin pointer, stall counter and per-port read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            stall_q     <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            if (state_q == IDLE && any_req) begin
                cmd_we_q    <= sel ? bus.p1_we    : bus.p0_we;
                cmd_addr_q  <= sel ? bus.p1_addr  : bus.p0_addr;
                cmd_wdata_q <= sel ? bus.p1_wdata : bus.p0_wdata;
                owner_q     <= sel;
                last_q      <= sel;
                stall_q     <= '0;
            end
            if (state_q == ISSUE && stall_q != '1) stall_q <= stall_q + SW'(1);
            if (state_q == WAIT_DONE && !cmd_we_q && bus.ctl_rd_ready) begin
                if (owner_q) rdata1_q <= bus.ctl_rd_data;
                else         rdata0_q <= bus.ctl_rd_data;
            end
        end
    end

    assign bus.p0_gnt        = gnt0;
    assign bus.p1_gnt        = gnt1;
    assign bus.p0_done       = done0;
    assign bus.p1_done       = done1;
    assign bus.p0_rdata      = rdata0_q;
    assign bus.p1_rdata      = rdata1_q;
    assign bus.ctl_wr_addr   = cmd_addr_q;
    assign bus.ctl_rd_addr   = cmd_addr_q;
    assign bus.ctl_wr_data   = cmd_wdata_q;
    assign bus.ctl_wr_enable = wr_en;
    assign bus.ctl_rd_enable = rd_en;
    assign bus.arb_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboarded bench: random/directed host traffic, a behavioural controller, and
// transaction-level expectations for grant order, issued commands and read data.
module tb_sdram_port_arbiter;
    localparam int unsigned AW = 24;

    typedef struct {
        int            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [15:0]   wd;
        int            gcyc;
    } cmd_t;
    typedef struct {
        int port;
        bit we;
    } exp_done_t;
    typedef struct {
        bit          rdy;
        logic [15:0] data;
    } ctl_res_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    cmd_t        cmd_q[$];
    exp_done_t   done_q[$];
    ctl_res_t    ctl_q[$];
    int          grant_log[$];
    logic [15:0] forced_q[$];
    logic [15:0] rd_model[2];
    int          last_model;
    int          force_ref;
    int          force_busy;

    sdram_port_arbiter_if #(.HADDR_WIDTH(AW)) bus ();

    sdram_port_arbiter #(.HADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic host_issue(input int p, input bit we, input logic [AW-1:0] a,
                              input logic [15:0] d, input bit imm);
        int w;
        w = 0;
        @(posedge clk); #1;
        if (p == 0) begin
            bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
        end else begin
            bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
        end
        forever begin
            @(negedge clk);
            if ((p == 0) ? bus.p0_gnt : bus.p1_gnt) break;
            w++;
            if (w > 2000) begin
                chk("gnt_timeout", 64'(w), 64'(0));
                break;
            end
        end
        if (imm) chk("gnt_latency", 64'(w), 64'(0));
        @(posedge clk); #1;
        if (p == 0) begin
            bus.p0_req = 1'b0; bus.p0_addr = AW'($urandom); bus.p0_wdata = 16'($urandom);
        end else begin
            bus.p1_req = 1'b0; bus.p1_addr = AW'($urandom); bus.p1_wdata = 16'($urandom);
        end
    endtask

    task automatic rand_host(input int p);
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            host_issue(p, 1'($urandom_range(0, 1)), AW'($urandom), 16'($urandom), 1'b0);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!bus.arb_busy && cmd_q.size() == 0 && done_q.size() == 0 &&
                !bus.p0_req && !bus.p1_req) break;
            n++;
            if (n > 3000) begin
                chk("idle_timeout", 64'(n), 64'(0));
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // Controller: optional refresh stall with strobe pending, then a busy window.
    task automatic ctl_serve();
        int          d, b;
        bit          is_rd, rdy;
        logic [15:0] dat;
        ctl_res_t    r;
        is_rd = bus.ctl_rd_enable;
        d = (force_ref >= 0) ? force_ref
                             : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        b = (force_busy >= 0) ? force_busy : int'($urandom_range(2, 5));
        force_ref  = -1;
        force_busy = -1;
        if (is_rd && forced_q.size() > 0) begin
            dat = forced_q.pop_front();
            rdy = 1'b1;
        end else begin
            dat = 16'($urandom);
            rdy = ($urandom_range(0, 4) != 0);
        end
        for (int i = 0; i < d; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!rst_n) return;
            chk("strobe_held", 64'(is_rd ? bus.ctl_rd_enable : bus.ctl_wr_enable), 64'(1));
        end
        @(posedge clk); #1;
        if (!rst_n) return;
        bus.ctl_busy = 1'b1;
        for (int k = 2; k <= b; k++) begin
            @(posedge clk); #1;
            if (!rst_n) begin
                bus.ctl_busy = 1'b0; bus.ctl_rd_ready = 1'b0;
                return;
            end
            if (k == b && is_rd && rdy) begin
                bus.ctl_rd_ready = 1'b1;
                bus.ctl_rd_data  = dat;
            end
            @(negedge clk);
            chk("strobe_dropped", 64'(bus.ctl_rd_enable | bus.ctl_wr_enable), 64'(0));
        end
        @(posedge clk); #1;
        bus.ctl_busy     = 1'b0;
        bus.ctl_rd_ready = 1'b0;
        bus.ctl_rd_data  = 16'($urandom);
        if (!rst_n) return;
        r.rdy  = rdy && is_rd;
        r.data = dat;
        ctl_q.push_back(r);
    endtask

    initial begin : ctl_model
        forever begin
            @(negedge clk);
            if (rst_n && (bus.ctl_rd_enable || bus.ctl_wr_enable)) ctl_serve();
        end
    end

    initial begin : cycle_checks
        forever begin
            @(negedge clk);
            chk("en_exclusive", 64'(bus.ctl_rd_enable & bus.ctl_wr_enable), 64'(0));
            chk("gnt_onehot", 64'(bus.p0_gnt & bus.p1_gnt), 64'(0));
            chk("done_onehot", 64'(bus.p0_done & bus.p1_done), 64'(0));
            chk("en_when_idle", 64'((bus.ctl_rd_enable | bus.ctl_wr_enable) & ~bus.arb_busy), 64'(0));
        end
    end

    // Grant side: fairness rule and expected command pushed for the later monitors.
    initial begin : grant_mon
        int        g;
        cmd_t      c;
        exp_done_t e;
        forever begin
            @(negedge clk);
            if (bus.p0_gnt || bus.p1_gnt) begin
                g = bus.p1_gnt ? 1 : 0;
                chk("gnt_req", 64'((g == 1) ? bus.p1_req : bus.p0_req), 64'(1));
                chk("gnt_idle", 64'(bus.arb_busy), 64'(0));
                if (bus.p0_req && bus.p1_req)
                    chk("gnt_round_robin", 64'(g), 64'((last_model == 1) ? 0 : 1));
                last_model = g;
                grant_log.push_back(g);
                c.port = g;
                c.we   = (g == 1) ? bus.p1_we    : bus.p0_we;
                c.addr = (g == 1) ? bus.p1_addr  : bus.p0_addr;
                c.wd   = (g == 1) ? bus.p1_wdata : bus.p0_wdata;
                c.gcyc = cyc;
                cmd_q.push_back(c);
                e.port = g;
                e.we   = c.we;
                done_q.push_back(e);
            end
        end
    end

    initial begin : strobe_mon
        bit   prev_en, en;
        cmd_t c;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            en = bus.ctl_rd_enable | bus.ctl_wr_enable;
            if (en && !prev_en) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_strobe", 64'(1), 64'(0));
                end else begin
                    c = cmd_q.pop_front();
                    chk("strobe_wr", 64'(bus.ctl_wr_enable), 64'(c.we));
                    chk("strobe_rd", 64'(bus.ctl_rd_enable), 64'(!c.we));
                    chk("wr_addr", 64'(bus.ctl_wr_addr), 64'(c.addr));
                    chk("rd_addr", 64'(bus.ctl_rd_addr), 64'(c.addr));
                    if (c.we) chk("wr_data", 64'(bus.ctl_wr_data), 64'(c.wd));
                    chk("strobe_latency", 64'(cyc), 64'(c.gcyc + 1));
                end
            end
            prev_en = en;
        end
    end

    initial begin : done_mon
        int        g;
        exp_done_t e;
        ctl_res_t  r;
        forever begin
            @(negedge clk);
            if (bus.p0_done || bus.p1_done) begin
                g = bus.p1_done ? 1 : 0;
                if (done_q.size() == 0 || ctl_q.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    e = done_q.pop_front();
                    r = ctl_q.pop_front();
                    chk("done_port", 64'(g), 64'(e.port));
                    if (!e.we && r.rdy) rd_model[e.port] = r.data;
                    chk("p0_rdata", 64'(bus.p0_rdata), 64'(rd_model[0]));
                    chk("p1_rdata", 64'(bus.p1_rdata), 64'(rd_model[1]));
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int n;
        rst_n = 1'b0;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus.ctl_busy = 1'b0; bus.ctl_rd_ready = 1'b0; bus.ctl_rd_data = '0;
        force_ref = -1; force_busy = -1; last_model = 1;
        rd_model[0] = '0; rd_model[1] = '0;
        checks = 0; failures = 0;

        repeat (3) @(posedge clk); #1;
        chk("reset_outputs", 64'({bus.p0_gnt, bus.p1_gnt, bus.p0_done, bus.p1_done,
                                  bus.ctl_rd_enable, bus.ctl_wr_enable, bus.arb_busy,
                                  bus.p0_rdata, bus.p1_rdata}), 64'(0));
        chk("reset_cmd", 64'({bus.ctl_wr_addr, bus.ctl_wr_data}), 64'(0));
        @(negedge clk); rst_n = 1'b1;

        // Simultaneous reads after reset: port 0 wins the first tie.
        grant_log.delete();
        forced_q.push_back(16'hA5A5);
        forced_q.push_back(16'h5A5A);
        fork
            host_issue(0, 1'b0, 24'h000100, 16'h0000, 1'b1);
            host_issue(1, 1'b0, 24'h000200, 16'h0000, 1'b0);
        join
        wait_idle();
        chk("tie_first", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'(0));
        chk("tie_second", 64'((grant_log.size() > 1) ? grant_log[1] : -1), 64'(1));
        chk("tie_p0_data", 64'(bus.p0_rdata), 64'(16'hA5A5));
        chk("tie_p1_data", 64'(bus.p1_rdata), 64'(16'h5A5A));

        host_issue(0, 1'b1, 24'h012345, 16'hBEEF, 1'b1);
        wait_idle();

        // Port 1 streams requests while port 0 asks once.
        grant_log.delete();
        fork
            for (int i = 0; i < 3; i++) host_issue(1, 1'b1, AW'($urandom), 16'($urandom), 1'b0);
            begin
                repeat (2) @(posedge clk);
                host_issue(0, 1'b0, 24'h000777, 16'h0000, 1'b0);
            end
        join
        wait_idle();
        chk("alt_0", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'(1));
        chk("alt_1", 64'((grant_log.size() > 1) ? grant_log[1] : -1), 64'(0));
        chk("alt_2", 64'((grant_log.size() > 2) ? grant_log[2] : -1), 64'(1));

        force_ref = 12;
        host_issue(0, 1'b0, 24'h0ABCDE, 16'h0000, 1'b1);
        wait_idle();

        fork
            rand_host(0);
            rand_host(1);
        join
        wait_idle();

        // Reset in the middle of a read's busy window.
        force_busy = 6;
        host_issue(0, 1'b0, 24'h0F0F0F, 16'h0000, 1'b1);
        n = 0;
        while (!bus.ctl_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("busy_seen", 64'(bus.ctl_busy), 64'(1));
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 64'({bus.p0_gnt, bus.p1_gnt, bus.p0_done, bus.p1_done,
                                  bus.ctl_rd_enable, bus.ctl_wr_enable, bus.arb_busy,
                                  bus.p0_rdata, bus.p1_rdata}), 64'(0));
        chk("abort_cmd", 64'({bus.ctl_rd_addr, bus.ctl_wr_data}), 64'(0));
        repeat (2) @(negedge clk);
        cmd_q.delete(); done_q.delete(); ctl_q.delete(); forced_q.delete();
        last_model = 1;
        rd_model[0] = '0; rd_model[1] = '0;
        rst_n = 1'b1;

        host_issue(1, 1'b1, 24'h00BEEF, 16'h1234, 1'b1);
        wait_idle();
        chk("post_reset_p0_rdata", 64'(bus.p0_rdata), 64'(0));
        chk("cmd_q_drained", 64'(cmd_q.size()), 64'(0));
        chk("ctl_q_drained", 64'(ctl_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
